// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder/accumulator: mode encoding and result sizing.
package adder_pkg;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_ACC = 1'b1
    } mode_e;

    // Packed result layout is {valid, carry, sum[WIDTH-1:0]}.
    localparam int unsigned RESULT_CTRL_BITS = 2;

    function automatic int unsigned result_width(input int unsigned width);
        return width + RESULT_CTRL_BITS;
    endfunction

endpackage

// File: rtl/pipe_delay.sv
// Synchronous-reset delay line for a packed result whose MSB is the valid bit.
// Data bits only load on valid slots; the valid bit always shifts. DEPTH=0 is a wire.
module pipe_delay #(
    parameter int unsigned WIDTH_D = 10,
    parameter int unsigned DEPTH   = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [WIDTH_D-1:0] in_data,
    output logic [WIDTH_D-1:0] out_data
);

    if (DEPTH == 0) begin : g_pass
        assign out_data = in_data;
    end else begin : g_pipe
        logic [WIDTH_D-1:0] stage_q [DEPTH];
        logic [WIDTH_D-1:0] stage_d [DEPTH];

        function automatic logic [WIDTH_D-1:0] advance(input logic [WIDTH_D-1:0] src,
                                                       input logic [WIDTH_D-1:0] cur);
            return src[WIDTH_D-1] ? src : {1'b0, cur[WIDTH_D-2:0]};
        endfunction

        always_comb begin
            stage_d[0] = advance(in_data, stage_q[0]);
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_d[i] = advance(stage_q[i-1], stage_q[i]);
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                stage_q <= stage_d;
            end
        end

        assign out_data = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/pipelined_add_accumulator.sv
// Fixed-latency unsigned adder / running-sum accumulator with valid tagging.
// Optional build macro SATURATE_EN clamps overflowing results (and acc) to all-ones.
module pipelined_add_accumulator
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_mode,
    input  logic             in_clear,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic [WIDTH-1:0] acc_value
);

    typedef struct packed {
        logic             valid;
        logic             carry;
        logic [WIDTH-1:0] sum;
    } result_t;

    localparam int unsigned RES_W = result_width(WIDTH);

    result_t          s1_q, s1_d;
    result_t          out_res;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             is_acc;

    always_comb begin
        is_acc = (mode_e'(in_mode) == MODE_ACC);
        base   = in_clear ? '0 : acc_q;
        addend = is_acc ? base : in_b;
        wide   = {1'b0, in_a} + {1'b0, addend};
        carry  = wide[WIDTH];
        sum    = wide[WIDTH-1:0];
`ifdef SATURATE_EN
        if (carry) begin
            sum = '1;
        end
`endif

        s1_d       = s1_q;
        s1_d.valid = in_valid;
        acc_d      = acc_q;
        if (in_valid) begin
            s1_d.carry = carry;
            s1_d.sum   = sum;
            if (is_acc) begin
                acc_d = sum;
            end else if (in_clear) begin
                acc_d = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q  <= '0;
            acc_q <= '0;
        end else begin
            s1_q  <= s1_d;
            acc_q <= acc_d;
        end
    end

    pipe_delay #(
        .WIDTH_D (RES_W),
        .DEPTH   (STAGES - 1)
    ) u_delay (
        .clock    (clock),
        .reset    (reset),
        .in_data  (s1_q),
        .out_data (out_res)
    );

    assign out_valid = out_res.valid;
    assign out_sum   = out_res.sum;
    assign out_carry = out_res.carry;
    assign acc_value = acc_q;

endmodule
